// File: rtl/acc_pkg.sv
// Shared constants for the accumulator stage: mux select codes, command codes
// and FSM state encoding.
package acc_pkg;

    localparam logic [1:0] SEL_A = 2'b11;
    localparam logic [1:0] SEL_B = 2'b10;
    localparam logic [1:0] SEL_C = 2'b01;
    localparam logic [1:0] SEL_D = 2'b00;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_ADD  = 2'b01;
    localparam logic [1:0] CMD_SUB  = 2'b10;
    localparam logic [1:0] CMD_CLR  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_EXEC = 2'b10;

endpackage

// File: rtl/acc_alu16.sv
// Combinational accumulator ALU: computes the next ACC value and Carry/borrow
// for LOAD/ADD/SUB/CLR, unsigned with wrap-around.
module acc_alu16
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mux_out,
    input  logic [1:0]       cmd_op,
    output logic [WIDTH-1:0] acc_next,
    output logic             carry_next
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, acc} + {1'b0, mux_out};

    always_comb begin
        acc_next   = '0;
        carry_next = 1'b0;
        case (cmd_op)
            CMD_LOAD: acc_next = mux_out;
            CMD_ADD:  {carry_next, acc_next} = sum;
            CMD_SUB: begin
                acc_next   = acc - mux_out;
                carry_next = (mux_out > acc);
            end
            default: begin
                acc_next   = '0;
                carry_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/acc_load_ctrl.sv
// Accumulator stage behind the 4:1 operand mux: accepts one command, drives the
// mux select, waits SEL_WAIT cycles for the mux to settle, then updates ACC.
module acc_load_ctrl
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned SEL_WAIT = 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             Cmd_Valid,
    output logic             Cmd_Ready,
    input  logic [1:0]       Cmd_Src,
    input  logic [1:0]       Cmd_Op,
    output logic [1:0]       OP,
    input  logic [WIDTH-1:0] Mux_Out,
    output logic [WIDTH-1:0] ACC,
    output logic             Zero,
    output logic             Carry,
    output logic             Done
);

    localparam int unsigned CNT_W = (SEL_WAIT > 1) ? $clog2(SEL_WAIT) : 1;

    if (SEL_WAIT < 1) begin : g_bad_sel_wait
        $error("acc_load_ctrl: SEL_WAIT must be >= 1");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] alu_acc;
    logic             alu_carry;

    acc_alu16 #(.WIDTH(WIDTH)) u_alu (
        .acc       (ACC),
        .mux_out   (Mux_Out),
        .cmd_op    (op_q),
        .acc_next  (alu_acc),
        .carry_next(alu_carry)
    );

    assign Cmd_Ready = (state == ST_IDLE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= CMD_LOAD;
            OP    <= SEL_D;
            ACC   <= '0;
            Zero  <= 1'b1;
            Carry <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Cmd_Valid) begin
                        OP    <= Cmd_Src;
                        op_q  <= Cmd_Op;
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // OP has been stable for SEL_WAIT cycles once cnt reaches SEL_WAIT-1
                    if (cnt == CNT_W'(SEL_WAIT - 1)) begin
                        state <= ST_EXEC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    ACC   <= alu_acc;
                    Carry <= alu_carry;
                    Zero  <= (alu_acc == '0);
                    Done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_load_ctrl.sv
// Scoreboard bench for acc_load_ctrl with a behavioural 4:1 operand mux fixture.
module tb_acc_load_ctrl;

    logic        CLK;
    logic        RESET_N;
    logic        Cmd_Valid;
    logic        Cmd_Ready;
    logic [1:0]  Cmd_Src;
    logic [1:0]  Cmd_Op;
    logic [1:0]  OP;
    logic [15:0] Mux_Out;
    logic [15:0] ACC;
    logic        Zero;
    logic        Carry;
    logic        Done;

    typedef struct packed {
        logic [15:0] acc;
        logic        zero;
        logic        carry;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_acc;
    int          checks;
    int          failures;
    int          accept_cnt;

    acc_load_ctrl #(.WIDTH(16), .SEL_WAIT(1)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .Cmd_Valid(Cmd_Valid),
        .Cmd_Ready(Cmd_Ready),
        .Cmd_Src  (Cmd_Src),
        .Cmd_Op   (Cmd_Op),
        .OP       (OP),
        .Mux_Out  (Mux_Out),
        .ACC      (ACC),
        .Zero     (Zero),
        .Carry    (Carry),
        .Done     (Done)
    );

    function automatic logic [15:0] operand(input logic [1:0] sel);
        case (sel)
            2'b11:   return 16'h0008;
            2'b10:   return 16'h0004;
            2'b01:   return 16'h0002;
            default: return 16'h0001;
        endcase
    endfunction

    assign Mux_Out = operand(OP);

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: evaluated when the DUT accepts a command
    always @(posedge CLK) begin
        if (RESET_N && Cmd_Valid && Cmd_Ready) begin
            logic [15:0] v;
            logic [16:0] s;
            exp_t        e;
            v = operand(Cmd_Src);
            e.carry = 1'b0;
            case (Cmd_Op)
                2'b00: model_acc = v;
                2'b01: begin
                    s = {1'b0, model_acc} + {1'b0, v};
                    model_acc = s[15:0];
                    e.carry = s[16];
                end
                2'b10: begin
                    e.carry = (v > model_acc);
                    model_acc = model_acc - v;
                end
                default: model_acc = 16'h0000;
            endcase
            e.acc  = model_acc;
            e.zero = (model_acc == 16'h0000);
            sb.push_back(e);
            accept_cnt++;
        end
    end

    always @(negedge CLK) begin
        if (Done) begin
            exp_t e;
            check_val("ready_on_done", 32'(Cmd_Ready), 32'd1);
            check_val("done_has_exp", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("acc", 32'(ACC), 32'(e.acc));
                check_val("zero", 32'(Zero), 32'(e.zero));
                check_val("carry", 32'(Carry), 32'(e.carry));
            end
        end
    end

    task automatic send(input logic [1:0] src, input logic [1:0] op);
        @(negedge CLK);
        Cmd_Src   = src;
        Cmd_Op    = op;
        Cmd_Valid = 1'b1;
        for (int i = 0; i < 20 && !Cmd_Ready; i++) @(negedge CLK);
        check_val("ready_before_accept", 32'(Cmd_Ready), 32'd1);
        @(posedge CLK);
        #1;
        Cmd_Valid = 1'b0;
        check_val("op_after_accept", 32'(OP), 32'(src));
        check_val("busy_after_accept", 32'(Cmd_Ready), 32'd0);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            cycles++;
            if (Done) break;
            check_val("ready_busy", 32'(Cmd_Ready), 32'd0);
        end
        if (!Done) check_val("done_timeout", 32'(Done), 32'd1);
    endtask

    initial begin
        int cyc;
        int base;
        checks     = 0;
        failures   = 0;
        accept_cnt = 0;
        model_acc  = 16'h0000;
        RESET_N    = 1'b1;
        Cmd_Valid  = 1'b0;
        Cmd_Src    = 2'b00;
        Cmd_Op     = 2'b00;

        // 1: asynchronous reset mid-clock
        #7 RESET_N = 1'b0;
        #1;
        check_val("rst_acc", 32'(ACC), 32'h0);
        check_val("rst_op", 32'(OP), 32'h0);
        check_val("rst_zero", 32'(Zero), 32'd1);
        check_val("rst_carry", 32'(Carry), 32'd0);
        check_val("rst_done", 32'(Done), 32'd0);
        check_val("rst_ready", 32'(Cmd_Ready), 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;

        // 2: LOAD A with latency check
        send(2'b11, 2'b00);
        wait_done(cyc);
        check_val("load_latency", 32'(cyc), 32'd3);
        @(negedge CLK);
        check_val("done_one_cycle", 32'(Done), 32'd0);

        // 3: two ADDs with Cmd_Valid held high throughout
        base = accept_cnt;
        @(negedge CLK);
        Cmd_Src   = 2'b10;
        Cmd_Op    = 2'b01;
        Cmd_Valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (accept_cnt == base + 1) Cmd_Src = 2'b01;
            if (accept_cnt == base + 2) begin
                Cmd_Valid = 1'b0;
                break;
            end
            check_val("ready_held", 32'(Cmd_Ready), 32'(Done));
        end
        Cmd_Valid = 1'b0;
        wait_done(cyc);
        repeat (4) @(negedge CLK);
        check_val("held_accepts", 32'(accept_cnt - base), 32'd2);
        check_val("acc_after_adds", 32'(ACC), 32'h000E);

        // 4: subtraction with borrow, then exact zero
        send(2'b10, 2'b00);
        wait_done(cyc);
        send(2'b11, 2'b10);
        wait_done(cyc);
        send(2'b00, 2'b00);
        wait_done(cyc);
        send(2'b00, 2'b10);
        wait_done(cyc);

        // 5: 0 - 1 -> 0xFFFF, ADD D wraps with carry, then CLR
        send(2'b00, 2'b10);
        wait_done(cyc);
        send(2'b00, 2'b01);
        wait_done(cyc);
        send(2'b11, 2'b11);
        wait_done(cyc);
        @(negedge CLK);
        check_val("op_holds", 32'(OP), 32'h3);

        // 6: reset during WAIT aborts; first edge after release accepts
        send(2'b11, 2'b00);
        RESET_N = 1'b0;
        #1;
        check_val("abort_acc", 32'(ACC), 32'h0);
        check_val("abort_ready", 32'(Cmd_Ready), 32'd1);
        check_val("abort_op", 32'(OP), 32'h0);
        sb.delete();
        model_acc = 16'h0000;
        repeat (3) @(negedge CLK) check_val("abort_no_done", 32'(Done), 32'd0);
        base = accept_cnt;
        RESET_N   = 1'b1;
        Cmd_Src   = 2'b10;
        Cmd_Op    = 2'b00;
        Cmd_Valid = 1'b1;
        @(posedge CLK);
        #1;
        Cmd_Valid = 1'b0;
        check_val("first_edge_accept", 32'(accept_cnt - base), 32'd1);
        wait_done(cyc);
        check_val("acc_after_abort", 32'(ACC), 32'h0004);

        repeat (3) @(negedge CLK);
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
